// File: rtl/cache_port_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_port_sequencer: round-robin sharing of cache channel 1, write-through.
// Revision 1.0
// ---------------------------------------------------------------------------
module cache_port_sequencer #(
  parameter int N               = 2,
  parameter int ADDR_WIDTH      = 8,
  parameter int LINE_WIDTH      = 32,
  parameter int MAX_FILL_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [N-1:0]            req_valid_i,
  input  logic [N-1:0]            req_write_i,
  input  logic [N*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N*LINE_WIDTH-1:0] req_wdata_i,
  output logic [N-1:0]            req_ready_o,
  output logic [N-1:0]            resp_valid_o,
  output logic                    resp_hit_o,
  output logic [LINE_WIDTH-1:0]   resp_rdata_o,
  output logic                    busy_o,
  output logic                    err_timeout_o,
  output logic [ADDR_WIDTH-1:0]   cache_addr_o,
  output logic [LINE_WIDTH-1:0]   cache_val_o,
  output logic                    cache_read_o,
  output logic                    cache_write_o,
  input  logic                    cache_hit_i,
  input  logic [LINE_WIDTH-1:0]   cache_out_val_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [LINE_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_ack_i,
  input  logic [LINE_WIDTH-1:0]   mem_rdata_i
);

  localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(MAX_FILL_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_CHECK = 3'd2,
    S_MEM_RD   = 3'd3,
    S_MEM_WR   = 3'd4,
    S_FILL     = 3'd5,
    S_RESP     = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   data_q, data_d;
  logic                    write_q, write_d;
  logic                    hit_q, hit_d;
  logic [CNT_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic                    err_q, err_d;

  logic                    grant_found;
  logic [ID_W-1:0]         winner;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return ID_W'(s);
  endfunction

  // Highest offset first so the requester closest to rr_ptr wins last.
  always_comb begin
    grant_found = 1'b0;
    winner      = rr_ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid_i[wrap_add(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        winner      = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    addr_d        = addr_q;
    data_d        = data_q;
    write_d       = write_q;
    hit_d         = hit_q;
    fill_cnt_d    = fill_cnt_q;
    err_d         = err_q;
    req_ready_o   = '0;
    resp_valid_o  = '0;
    resp_hit_o    = 1'b0;
    resp_rdata_o  = '0;
    cache_addr_o  = '0;
    cache_val_o   = '0;
    cache_read_o  = 1'b0;
    cache_write_o = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found && reset_ni) begin
          req_ready_o[winner] = 1'b1;
          rr_ptr_d   = wrap_add(winner, 1);
          id_d       = winner;
          addr_d     = req_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
          data_d     = req_wdata_i[winner*LINE_WIDTH +: LINE_WIDTH];
          write_d    = req_write_i[winner];
          hit_d      = 1'b0;
          fill_cnt_d = '0;
          state_d    = req_write_i[winner] ? S_MEM_WR : S_RD_ISSUE;
        end
      end

      S_RD_ISSUE: begin
        cache_read_o = 1'b1;
        cache_addr_o = addr_q;
        state_d      = S_RD_CHECK;
      end

      S_RD_CHECK: begin
        if (cache_hit_i) begin
          data_d  = cache_out_val_i;
          hit_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_MEM_RD;
        end
      end

      S_MEM_RD, S_MEM_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = (state_q == S_MEM_WR);
        mem_addr_o  = addr_q;
        mem_wdata_o = (state_q == S_MEM_WR) ? data_q : '0;
        if (mem_ack_i) begin
          if (state_q == S_MEM_RD) data_d = mem_rdata_i;
          state_d = S_FILL;
        end
      end

      // The hit seen in the first FILL cycle belongs to the previous cache op.
      S_FILL: begin
        cache_write_o = 1'b1;
        cache_addr_o  = addr_q;
        cache_val_o   = data_q;
        if ((fill_cnt_q != '0) && cache_hit_i) begin
          state_d = S_RESP;
        end else if (fill_cnt_q == CNT_W'(MAX_FILL_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        resp_valid_o[id_q] = 1'b1;
        resp_hit_o         = hit_q;
        resp_rdata_o       = data_q;
        state_d            = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      hit_q      <= 1'b0;
      fill_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      write_q    <= write_d;
      hit_q      <= hit_d;
      fill_cnt_q <= fill_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign err_timeout_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_port_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_port_sequencer: directed bench with 2-line CLOCK cache and memory models.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cache_port_sequencer;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int LW = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic            resp_hit, busy, err_timeout;
  logic [LW-1:0]   resp_rdata;
  logic [AW-1:0]   cache_addr, mem_addr;
  logic [LW-1:0]   cache_val, mem_wdata;
  logic            cache_read, cache_write, mem_req, mem_we;
  logic            mem_ack = 1'b0;
  logic [LW-1:0]   mem_rdata = '0;
  logic            stub = 1'b0;
  logic            cache_hit_dut;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_overlap = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cache_read && cache_write) n_overlap <= n_overlap + 1;

  // Cache model: 2 lines, CLOCK replacement, one sweep step per cycle, sticky registered hit.
  logic          cv [0:1] = '{1'b0, 1'b0};
  logic          cr [0:1] = '{1'b0, 1'b0};
  logic [AW-1:0] ca [0:1] = '{8'h00, 8'h00};
  logic [LW-1:0] cd [0:1] = '{32'h0, 32'h0};
  int            hand = 0;
  logic          hit_m = 1'b0;
  logic [LW-1:0] cov = '0;
  logic          wdone = 1'b0;
  int            wmatch;

  always_comb begin
    wmatch = -1;
    for (int i = 0; i < 2; i++) if (cv[i] && ca[i] == cache_addr) wmatch = i;
  end

  always @(posedge clk) begin
    if (cache_read) begin
      hit_m <= 1'b0;
      wdone <= 1'b0;
      for (int i = 0; i < 2; i++)
        if (cv[i] && ca[i] == cache_addr) begin hit_m <= 1'b1; cov <= cd[i]; cr[i] <= 1'b1; end
    end else if (cache_write) begin
      if (!wdone) begin
        if (wmatch >= 0) begin
          cd[wmatch] <= cache_val; cr[wmatch] <= 1'b1; hit_m <= 1'b1; wdone <= 1'b1;
        end else if (cv[hand] && cr[hand]) begin
          cr[hand] <= 1'b0; hand <= (hand + 1) % 2; hit_m <= 1'b0;
        end else begin
          cv[hand] <= 1'b1; ca[hand] <= cache_addr; cd[hand] <= cache_val; cr[hand] <= 1'b1;
          hit_m <= 1'b1; wdone <= 1'b1;
        end
      end
    end else begin
      wdone <= 1'b0;
    end
  end

  assign cache_hit_dut = stub ? 1'b0 : hit_m;

  // Memory model: ack two cycles after mem_req rises; unwritten words hold preset values.
  logic [LW-1:0] mem [0:255];
  bit            written [0:255] = '{default: 1'b0};
  int            mw = 0;
  int            n_mem_rd = 0;
  int            n_mem_wr = 0;
  logic [AW-1:0] last_mem_addr = '0;

  function automatic logic [LW-1:0] preset(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    if (a == 8'h20) return 32'h12345678;
    return {24'h0, a};
  endfunction

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (mem_req && !mem_ack) begin
      if (mw == 1) begin
        mem_ack <= 1'b1;
        mw <= 0;
        last_mem_addr <= mem_addr;
        if (mem_we) begin
          mem[mem_addr] <= mem_wdata; written[mem_addr] <= 1'b1; n_mem_wr <= n_mem_wr + 1;
        end else begin
          mem_rdata <= written[mem_addr] ? mem[mem_addr] : preset(mem_addr);
          n_mem_rd <= n_mem_rd + 1;
        end
      end else begin
        mw <= mw + 1;
      end
    end else begin
      mw <= 0;
    end
  end

  cache_port_sequencer #(.N(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_FILL_CYCLES(8)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_rdata_o(resp_rdata),
    .busy_o(busy), .err_timeout_o(err_timeout),
    .cache_addr_o(cache_addr), .cache_val_o(cache_val), .cache_read_o(cache_read), .cache_write_o(cache_write),
    .cache_hit_i(cache_hit_dut), .cache_out_val_i(cov),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns grant-to-response latency in cycles.
  task automatic do_req(input string tag, input int id, input logic wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] d, output int lat, output logic hit, output logic [LW-1:0] rd);
    int  tg;
    bit  got;
    tg = -1; lat = -1; hit = 1'b0; rd = '0; got = 1'b0;
    req_valid[id] = 1'b1; req_write[id] = wr;
    req_addr[id*AW +: AW] = a; req_wdata[id*LW +: LW] = d;
    for (int i = 0; i < 20 && tg < 0; i++) begin
      #1;
      if (req_ready[id]) tg = cyc;
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
    if (tg < 0) begin
      check({tag, "_grant_timeout"}, 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < 40 && !got; i++) begin
        if (resp_valid[id]) begin
          got = 1'b1; lat = cyc - tg; hit = resp_hit; rd = resp_rdata;
        end
        @(negedge clk);
      end
      if (!got) check({tag, "_resp_timeout"}, 32'd0, 32'd1);
    end
  endtask

  int            lat, base_rd, base_wr, ng, nresp;
  logic          hit;
  logic [LW-1:0] rd;
  logic [N-1:0]  grants [0:3];
  bit            got;

  initial begin
    // Reset with a pending request: nothing may be granted or driven.
    reset_n = 1'b0; req_valid = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy_err", 32'({busy, err_timeout}), 32'd0);
    check("rst_strobes", 32'({cache_read, cache_write, mem_req, mem_we, resp_valid}), 32'd0);
    check("rst_addr", 32'({cache_addr, mem_addr}), 32'd0);
    req_valid = '0; reset_n = 1'b1;
    @(negedge clk);

    // Read miss fills from memory, then repeated reads hit.
    base_rd = n_mem_rd;
    do_req("rd10_miss", 0, 1'b0, 8'h10, '0, lat, hit, rd);
    check("rd10_miss_lat", 32'(lat), 32'd8);
    check("rd10_miss_hit", 32'(hit), 32'd0);
    check("rd10_miss_data", rd, 32'hDEADBEEF);
    check("rd10_miss_memrd", 32'(n_mem_rd - base_rd), 32'd1);
    check("rd10_miss_memaddr", 32'(last_mem_addr), 32'h10);
    do_req("rd10_hit", 0, 1'b0, 8'h10, '0, lat, hit, rd);
    check("rd10_hit_lat", 32'(lat), 32'd3);
    check("rd10_hit_hit", 32'(hit), 32'd1);
    check("rd10_hit_data", rd, 32'hDEADBEEF);
    check("rd10_hit_nomem", 32'(n_mem_rd - base_rd), 32'd1);
    do_req("rd10_r1", 1, 1'b0, 8'h10, '0, lat, hit, rd);
    check("rd10_r1_lat", 32'(lat), 32'd3);
    check("rd10_r1_data", rd, 32'hDEADBEEF);

    // Both requesters held: grants must alternate.
    req_write = '0; req_addr = {8'h10, 8'h10}; req_valid = 2'b11; ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      #1;
      if (req_ready != '0) begin grants[ng] = req_ready; ng++; end
      @(negedge clk);
    end
    req_valid = '0;
    check("rr_count", 32'(ng), 32'd4);
    check("rr_g0", 32'(grants[0]), 32'd1);
    check("rr_g1", 32'(grants[1]), 32'd2);
    check("rr_g2", 32'(grants[2]), 32'd1);
    check("rr_g3", 32'(grants[3]), 32'd2);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);

    // Write-through with evictions.
    base_wr = n_mem_wr;
    do_req("wr01", 0, 1'b1, 8'h01, 32'hA1, lat, hit, rd);
    check("wr01_lat", 32'(lat), 32'd7);
    check("wr01_hit", 32'(hit), 32'd0);
    do_req("wr02", 0, 1'b1, 8'h02, 32'hA2, lat, hit, rd);
    check("wr02_lat", 32'(lat), 32'd7);
    do_req("wr03", 0, 1'b1, 8'h03, 32'hA3, lat, hit, rd);
    check("wr03_lat", 32'(lat), 32'd7);
    check("wr_mem_count", 32'(n_mem_wr - base_wr), 32'd3);
    check("wr_mem_lastaddr", 32'(last_mem_addr), 32'h03);
    do_req("rd01", 0, 1'b0, 8'h01, '0, lat, hit, rd);
    check("rd01_hit", 32'(hit), 32'd0);
    check("rd01_data", rd, 32'hA1);
    check("rd01_lat", 32'(lat), 32'd9);
    do_req("rd03", 0, 1'b0, 8'h03, '0, lat, hit, rd);
    check("rd03_hit", 32'(hit), 32'd1);
    check("rd03_data", rd, 32'hA3);
    check("rd03_lat", 32'(lat), 32'd3);

    // Cache never confirms the fill: timeout after 8 FILL cycles, sticky flag.
    stub = 1'b1;
    do_req("wr05_to", 1, 1'b1, 8'h05, 32'hB5, lat, hit, rd);
    stub = 1'b0;
    check("wr05_lat", 32'(lat), 32'd12);
    check("wr05_hit", 32'(hit), 32'd0);
    check("wr05_err", 32'(err_timeout), 32'd1);
    do_req("rd03_after", 0, 1'b0, 8'h03, '0, lat, hit, rd);
    check("rd03_after_data", rd, 32'hA3);
    check("err_sticky", 32'(err_timeout), 32'd1);

    // Reset while waiting on memory: request dropped cleanly.
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[7:0] = 8'h20; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin #1; if (req_ready[0]) got = 1'b1; @(negedge clk); end
    req_valid[0] = 1'b0;
    check("rst_mid_grant", 32'(got), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin if (mem_req) got = 1'b1; else @(negedge clk); end
    check("rst_mid_memreq", 32'(got), 32'd1);
    base_rd = n_mem_rd;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_memreq_low", 32'(mem_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_err_clr", 32'(err_timeout), 32'd0);
    reset_n = 1'b1; nresp = 0;
    repeat (8) begin @(negedge clk); if (resp_valid != '0 || mem_req) nresp++; end
    check("rst_mid_quiet", 32'(nresp), 32'd0);
    check("rst_mid_no_memrd", 32'(n_mem_rd - base_rd), 32'd0);
    do_req("rd20", 0, 1'b0, 8'h20, '0, lat, hit, rd);
    check("rd20_hit", 32'(hit), 32'd0);
    check("rd20_data", rd, 32'h12345678);
    check("rd20_lat", 32'(lat), 32'd10);

    check("strobe_overlap", 32'(n_overlap), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
